// File: rtl/board_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : board_shifter
//  Description : Sequential 2048 move engine. Captures a 4x4 board of 4-bit
//                tile exponents and a direction, then slides and merges one
//                line per cycle. It returns the moved board, the score
//                increment and a moved flag, qualified by a one-cycle done.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_shifter #(
    parameter int MAX_EXP = 15,
    parameter int SCORE_W = 20
) (
    input  logic               clk,
    input  logic               rst,        // asynchronous, active-low
    input  logic               start,
    input  logic [1:0]         dir,
    input  logic [63:0]        in_board,
    output logic               busy,
    output logic               done,
    output logic [63:0]        out_board,
    output logic               moved,
    output logic [SCORE_W-1:0] score_inc
);

    // Direction encoding
    localparam logic [1:0] c_dir_up    = 2'b00;
    localparam logic [1:0] c_dir_down  = 2'b01;
    localparam logic [1:0] c_dir_left  = 2'b10;
    localparam logic [1:0] c_dir_right = 2'b11;

    // FSM encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_line = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [3:0] c_max_exp = 4'(MAX_EXP);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [1:0]         r_cnt;
    logic [1:0]         r_dir;
    logic [63:0]        r_in_board;
    logic [63:0]        r_work;
    logic [SCORE_W-1:0] r_acc;
    logic [63:0]        r_out_board;
    logic               r_moved;
    logic [SCORE_W-1:0] r_score;

    // Current line in leading-edge order, its compressed and merged forms
    logic [3:0][3:0]    w_line_in;
    logic [3:0][3:0]    w_comp;
    logic [3:0][3:0]    w_line_out;
    logic [SCORE_W-1:0] w_line_score;
    logic [63:0]        w_board_next;

    // Tile index of position p (0 = leading edge) within line k.
    // The index is row*4+col, so it is just {row, col} in two-bit fields.
    function automatic logic [3:0] f_tile_idx(
        input logic [1:0] d,
        input logic [1:0] k,
        input logic [1:0] p
    );
        logic [3:0] v_idx;
        case (d)
            c_dir_left:  v_idx = {k, p};
            c_dir_right: v_idx = {k, ~p};
            c_dir_up:    v_idx = {p, k};
            c_dir_down:  v_idx = {~p, k};
            default:     v_idx = {k, p};
        endcase
        return v_idx;
    endfunction

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a start outside IDLE is simply dropped
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (start) w_state_next = c_st_load;
            c_st_load: w_state_next = c_st_line;
            c_st_line: if (r_cnt == 2'd3) w_state_next = c_st_done;
            c_st_done: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_st_load: busy = 1'b1;
            c_st_line: busy = 1'b1;
            c_st_done: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Line datapath
    // ------------------------------------------------------------------

    // Gather the tiles of line r_cnt from the work board
    always_comb begin
        w_line_in = '0;
        for (int p = 0; p < 4; p++) begin
            w_line_in[p] = r_work[{f_tile_idx(r_dir, r_cnt, 2'(p)), 2'b00} +: 4];
        end
    end

    // Slide non-empty tiles towards the leading edge, order preserved
    always_comb begin : b_compress
        logic [1:0] v_wp;
        w_comp = '0;
        v_wp   = 2'd0;
        for (int j = 0; j < 4; j++) begin
            if (w_line_in[j] != 4'd0) begin
                w_comp[v_wp] = w_line_in[j];
                v_wp         = v_wp + 2'd1;
            end
        end
    end

    // Merge equal neighbours from the leading edge. The second tile of a
    // pair is consumed (v_skip), so a merged tile never merges again, and
    // outputs are packed forward so the line stays compressed.
    always_comb begin : b_merge
        logic [4:0][3:0] v_ext;
        logic [1:0]      v_wp;
        logic            v_skip;
        logic [3:0]      v_e1;
        v_ext        = {4'd0, w_comp};
        v_wp         = 2'd0;
        v_skip       = 1'b0;
        v_e1         = 4'd0;
        w_line_out   = '0;
        w_line_score = '0;
        for (int j = 0; j < 4; j++) begin
            if (v_skip) begin
                v_skip = 1'b0;
            end else if (v_ext[j] != 4'd0) begin
                if ((v_ext[j] == v_ext[j+1]) && (v_ext[j] < c_max_exp)) begin
                    v_e1             = v_ext[j] + 4'd1;
                    w_line_out[v_wp] = v_e1;
                    w_line_score     = w_line_score + (SCORE_W'(1) << v_e1);
                    v_skip           = 1'b1;
                end else begin
                    w_line_out[v_wp] = v_ext[j];
                end
                v_wp = v_wp + 2'd1;
            end
        end
    end

    // Write the processed line back to the tile positions it came from
    always_comb begin
        w_board_next = r_work;
        for (int p = 0; p < 4; p++) begin
            w_board_next[{f_tile_idx(r_dir, r_cnt, 2'(p)), 2'b00} +: 4] = w_line_out[p];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Command capture, work board, line counter and score accumulation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_board <= '0;
            r_dir      <= 2'd0;
            r_work     <= '0;
            r_acc      <= '0;
            r_cnt      <= 2'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_in_board <= in_board;
                        r_dir      <= dir;
                    end
                end
                c_st_load: begin
                    r_work <= r_in_board;
                    r_acc  <= '0;
                    r_cnt  <= 2'd0;
                end
                c_st_line: begin
                    r_work <= w_board_next;
                    r_acc  <= r_acc + w_line_score;
                    r_cnt  <= r_cnt + 2'd1;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Result registers: loaded with the last line so they are valid with done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_board <= '0;
            r_moved     <= 1'b0;
            r_score     <= '0;
        end else if ((r_state == c_st_line) && (r_cnt == 2'd3)) begin
            r_out_board <= w_board_next;
            r_moved     <= (w_board_next != r_in_board);
            r_score     <= r_acc + w_line_score;
        end
    end

    assign out_board = r_out_board;
    assign moved     = r_moved;
    assign score_inc = r_score;

endmodule
`default_nettype wire

// File: tb/tb_board_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_shifter
//  Description : Self-checking bench for board_shifter. Directed cases plus
//                random boards compared against a queue-based move model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  dir;
    logic [63:0] in_board;
    logic        busy;
    logic        done;
    logic [63:0] out_board;
    logic        moved;
    logic [19:0] score_inc;

    int checks = 0;
    int errors = 0;

    board_shifter #(.MAX_EXP(15), .SCORE_W(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir       (dir),
        .in_board  (in_board),
        .busy      (busy),
        .done      (done),
        .out_board (out_board),
        .moved     (moved),
        .score_inc (score_inc)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: a 2048 move on a grid, one line at a time using queues
    function automatic void ref_move(input logic [63:0] b, input logic [1:0] d,
                                     output logic [63:0] nb, output int sc);
        int g[4][4];
        sc = 0;
        for (int i = 0; i < 16; i++) g[i / 4][i % 4] = int'(b[4*i +: 4]);
        for (int k = 0; k < 4; k++) begin
            int rr[4];
            int cc[4];
            int q[$];
            int res[$];
            int i;
            for (int p = 0; p < 4; p++) begin
                case (d)
                    2'b00:   begin rr[p] = p;     cc[p] = k;     end
                    2'b01:   begin rr[p] = 3 - p; cc[p] = k;     end
                    2'b10:   begin rr[p] = k;     cc[p] = p;     end
                    default: begin rr[p] = k;     cc[p] = 3 - p; end
                endcase
                if (g[rr[p]][cc[p]] != 0) q.push_back(g[rr[p]][cc[p]]);
            end
            i = 0;
            while (i < q.size()) begin
                if (i + 1 < q.size() && q[i] == q[i+1] && q[i] < 15) begin
                    res.push_back(q[i] + 1);
                    sc += 2 ** (q[i] + 1);
                    i += 2;
                end else begin
                    res.push_back(q[i]);
                    i += 1;
                end
            end
            while (res.size() < 4) res.push_back(0);
            for (int p = 0; p < 4; p++) g[rr[p]][cc[p]] = res[p];
        end
        nb = '0;
        for (int i = 0; i < 16; i++) nb[4*i +: 4] = 4'(g[i / 4][i % 4]);
    endfunction

    // One move: timing of busy/done, then result vs model (and vs exp_b if given)
    task automatic run_move(input string tag, input logic [63:0] b, input logic [1:0] d,
                            input bit inject, input bit use_exp,
                            input logic [63:0] exp_b, input int exp_s);
        logic [63:0] mb;
        int          ms;
        ref_move(b, d, mb, ms);
        if (use_exp) begin
            mb = exp_b;
            ms = exp_s;
        end
        @(negedge clk);
        for (int w = 0; w < 4 && (busy || done); w++) @(negedge clk);
        chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
        start = 1'b1; dir = d; in_board = b;
        @(posedge clk); #1;
        start = 1'b0; dir = 2'($urandom); in_board = {$urandom, $urandom};
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("%s_bd%0d", tag, j), {62'd0, busy, done},
                (j < 5) ? 64'd2 : 64'd1);
            if (j < 5) begin
                if (inject && j == 1) begin
                    start = 1'b1; dir = ~d; in_board = ~b;
                end
                if (j == 2) start = 1'b0;
                @(posedge clk); #1;
            end
        end
        chk({tag, "_board"}, out_board, mb);
        chk({tag, "_score"}, 64'(score_inc), 64'(ms));
        chk({tag, "_moved"}, 64'(moved), 64'(mb != b));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        logic [63:0] rb;
        bit          saw_done;
        rst = 1'b0; start = 1'b0; dir = 2'd0; in_board = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_status", {62'd0, busy, done}, 64'd0);
        chk("rst_board", out_board, 64'd0);
        chk("rst_score_moved", {43'd0, score_inc, moved}, 64'd0);
        @(negedge clk); rst = 1'b1;

        // Directed cases with hand-derived expectations
        run_move("left_1111", 64'h0000_0000_0000_1111, 2'b10, 1'b0, 1'b1, 64'h0022, 8);
        run_move("left_1120", 64'h0000_0000_0000_0211, 2'b10, 1'b0, 1'b1, 64'h0022, 4);
        run_move("up_col0",   64'h0003_0000_0003_0000, 2'b00, 1'b0, 1'b1, 64'h0004, 16);
        run_move("down_col0", 64'h0003_0000_0003_0000, 2'b01, 1'b0, 1'b1,
                 64'h0004_0000_0000_0000, 16);
        run_move("right_max", 64'h0000_0000_0000_00FF, 2'b11, 1'b0, 1'b1, 64'hFF00, 0);
        run_move("right_nop", 64'h0000_0000_0000_FF00, 2'b11, 1'b0, 1'b1, 64'hFF00, 0);
        run_move("busy_start", 64'h1111_2222_0303_0440, 2'b10, 1'b1, 1'b0, '0, 0);

        // Reset during LINE cycle 2
        @(negedge clk);
        start = 1'b1; dir = 2'b01; in_board = 64'h1212_3030_0404_5005;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; #1;
        chk("abort_status", {62'd0, busy, done}, 64'd0);
        chk("abort_board", out_board, 64'd0);
        chk("abort_score_moved", {43'd0, score_inc, moved}, 64'd0);
        @(negedge clk); rst = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort_nodone", 64'(saw_done), 64'd0);
        run_move("after_abort", 64'h1212_3030_0404_5005, 2'b01, 1'b0, 1'b0, '0, 0);

        // Random boards in all directions, biased towards small exponents
        for (int n = 0; n < 40; n++) begin
            rb = '0;
            for (int t = 0; t < 16; t++) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 4)       rb[4*t +: 4] = 4'd0;
                else if (r == 9) rb[4*t +: 4] = 4'd15;
                else             rb[4*t +: 4] = 4'($urandom_range(1, 3));
            end
            run_move($sformatf("rnd%0d", n), rb, 2'($urandom), n[3], 1'b0, '0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
